serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
Framed serial transmitter. It accepts a parallel word through a ready/load handshake and drives it one bit per clock onto a single serial line, y_out. Each frame is a start bit, the data MSB first, an even-parity bit, a stop bit, and then a programmable idle gap. The block is the transmitting end that feeds the team's single-bit-input sequence-detector state machines, and it also drives their benches.

Parameters:
DATA_WIDTH, 8, payload bits per frame (>= 2)
GAP_CYCLES, 2, idle cycles forced after the stop bit before the next load is accepted (0 allowed)

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_WIDTH  word to send; sampled only on an accepted load
load_in  input  1  load request; accepted when load_in=1 and ready_out=1 at a rising edge
ready_out  output  1  1 only in IDLE; block can accept a word
y_out  output  1  registered serial line; idle level 0
busy_out  output  1  1 whenever state != IDLE
done_out  output  1  1 for exactly the one cycle in which the stop bit is on y_out

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE, y_out=0, done_out=0, busy_out=0, ready_out=1.
  - Shift register and counters are cleared.
  - No load is captured while reset=1.
  - The first load can be accepted at the first rising edge after reset deasserts.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE: y_out=0. An accepted load captures data_in into the shift register, computes parity = XOR of data_in, and moves to START.
  - START: y_out=1 for 1 cycle, then DATA with bit counter = DATA_WIDTH-1.
  - DATA: y_out = shift_reg[MSB]; shift left each cycle. Stays DATA_WIDTH cycles, then PARITY.
  - PARITY: y_out = stored even-parity bit (total ones in data+parity is even). 1 cycle, then STOP.
  - STOP: y_out=0 and done_out=1 for 1 cycle. Goes to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: y_out=0 for GAP_CYCLES cycles, then IDLE.
- Latency and throughput:
  - The start bit appears on y_out in the cycle after the accepting edge.
  - Frame length on the line is DATA_WIDTH+3 cycles.
  - ready_out returns DATA_WIDTH+3+GAP_CYCLES cycles after the accepting edge.
  - With GAP_CYCLES=0, back-to-back frames are separated by exactly one IDLE cycle, because the load is accepted in IDLE.
- Boundary conditions:
  - load_in while busy: ignored, with no queuing. data_in changes during a frame have no effect.
  - load_in held high continuously: a new frame starts at each return to IDLE, one IDLE cycle between frames.
  - All outputs are registered or state-decoded; there are no combinational paths from inputs to outputs.
  - Bit counter width is clog2(DATA_WIDTH). Gap counter width is clog2(GAP_CYCLES+1) and is unused when GAP_CYCLES=0.
  - Illegal state encodings recover to IDLE with y_out=0.

Decomposition:
- Shared package serial_frame_pkg:
  - state encoding localparams (IDLE..GAP);
  - START_BIT=1, STOP_BIT=0, IDLE_LEVEL=0;
  - parity-sense constant (even).
- The matching receiver and benches import the same package.
- Sub-module frame_shift_reg (parameterised by DATA_WIDTH): parallel load, shift-left enable, MSB out, async reset. The FSM, bit counter, gap counter and parity register stay in the top.

Test Plan:
- Reset then idle: reset=1 for 10 ns, release, load_in=0 for 20 cycles -> y_out=0, ready_out=1, busy_out=0, done_out=0 throughout.
- Single frame: data_in=8'hA5 with 1-cycle load_in.
  - y_out over the next 11 cycles = 1, 1,0,1,0,0,1,0,1, 0(parity), 0(stop).
  - done_out high only in the stop cycle.
  - ready_out back high 13 cycles after the accepting edge.
- Odd parity data: data_in=8'h07 -> parity bit 1; data_in=8'h00 -> all data bits 0, parity 0, frame still 1 followed by 10 zeros.
- Load while busy: load 8'hFF, then pulse load_in with 8'h00 at cycle 4 -> the second load is ignored, y_out carries all ones for 8 data bits, parity 0, and no second frame.
- Reset mid-frame: assert reset during the 3rd data bit of 8'hA5 -> y_out=0 and ready_out=1 immediately, without waiting for a clock edge. After release, a load of 8'h3C produces a clean full frame.
- Back-to-back with GAP_CYCLES=0 and load_in held high: data 8'h81 then 8'h18 -> exactly one 0 idle cycle between stop and the next start, and two done_out pulses 12 cycles apart.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the framed serial transmitter and its matching receiver.
// Holds the state encoding, fixed line levels and the parity sense.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StGap    = 3'd5
  } state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  // 0 selects even parity: data ones plus the parity bit give an even count.
  localparam logic PARITY_ODD = 1'b0;

  function automatic logic parity_bit(input logic data_xor);
    return data_xor ^ PARITY_ODD;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Load handshake and serial line bundle for serial_frame_tx.
// The master side supplies words; the slave side is the transmitter.
interface serial_frame_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] data_in;
  logic                  load_in;
  logic                  ready_out;
  logic                  y_out;
  logic                  busy_out;
  logic                  done_out;

  modport master (
    output data_in,
    output load_in,
    input  ready_out,
    input  y_out,
    input  busy_out,
    input  done_out
  );

  modport slave (
    input  data_in,
    input  load_in,
    output ready_out,
    output y_out,
    output busy_out,
    output done_out
  );

endinterface

// File: rtl/frame_shift_reg.sv
// Payload shift register: parallel load, shift-left enable, MSB presented first.
// Load has priority over shift.
module frame_shift_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  msb_o
);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[DATA_WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, MSB-first data, even parity, stop bit, idle gap.
// Line outputs are decoded from registered state only, so nothing combinational reaches them.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  serial_frame_tx_if.slave   bus
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  // Gap counter is kept one bit wide when there is no gap so the code stays legal.
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GapLast = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            parity_q, parity_d;
  logic            accept;
  logic            shift_en;
  logic            sr_msb;
  logic            y;
  logic            done;

  assign accept = bus.load_in && (state_q == StIdle);

  frame_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (accept),
    .shift_i (shift_en),
    .data_i  (bus.data_in),
    .msb_o   (sr_msb)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    parity_d  = parity_q;
    shift_en  = 1'b0;
    y         = IDLE_LEVEL;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.load_in) begin
          parity_d = parity_bit(^bus.data_in);
          state_d  = StStart;
        end
      end
      StStart: begin
        y         = START_BIT;
        bit_cnt_d = CntLast;
        state_d   = StData;
      end
      StData: begin
        y        = sr_msb;
        shift_en = 1'b1;
        if (bit_cnt_q == '0) begin
          state_d = StParity;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      StParity: begin
        y       = parity_q;
        state_d = StStop;
      end
      StStop: begin
        y    = STOP_BIT;
        done = 1'b1;
        if (GAP_CYCLES > 0) begin
          gap_cnt_d = GapLast;
          state_d   = StGap;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      parity_q  <= parity_d;
    end
  end

  assign bus.y_out     = y;
  assign bus.done_out  = done;
  assign bus.ready_out = (state_q == StIdle);
  assign bus.busy_out  = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one instance with the default gap, one with no gap.
// Expected frames are written out by hand as {start, data MSB first, parity, stop}.
module tb_serial_frame_tx;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fails;

  serial_frame_tx_if #(.DATA_WIDTH(8)) bus  ();
  serial_frame_tx_if #(.DATA_WIDTH(8)) bus0 ();

  serial_frame_tx #(
    .DATA_WIDTH (8),
    .GAP_CYCLES (2)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  serial_frame_tx #(
    .DATA_WIDTH (8),
    .GAP_CYCLES (0)
  ) u_dut_gap0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Collects 11 line cycles starting at the edge that accepts the pending load.
  task automatic capture_frame(input bit gap0, input int pulse_at, input logic [7:0] pulse_data,
                               output logic [10:0] bits, output logic [10:0] dones);
    @(posedge clock); #1;
    if (gap0) bus0.load_in = 1'b0;
    else      bus.load_in  = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == pulse_at) begin
        bus.data_in = pulse_data;
        bus.load_in = 1'b1;
      end else if (i == pulse_at + 1) begin
        bus.load_in = 1'b0;
      end
      bits[10-i]  = gap0 ? bus0.y_out : bus.y_out;
      dones[10-i] = gap0 ? bus0.done_out : bus.done_out;
      if (i < 10) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (bus.ready_out !== 1'b1 && cycles < 40) begin
      @(posedge clock); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.load_in  = 1'b0;
    bus.data_in  = 8'h00;
    bus0.load_in = 1'b0;
    bus0.data_in = 8'h00;
    #9;
    n_checks++;
    if (bus.ready_out !== 1'b1 || bus.y_out !== 1'b0 || bus.busy_out !== 1'b0 ||
        bus.done_out !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: y=%b ready=%b busy=%b done=%b, want 0 1 0 0",
               bus.y_out, bus.ready_out, bus.busy_out, bus.done_out);
    end
    #1 reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (bus.ready_out !== 1'b1 || bus.y_out !== 1'b0 || bus.busy_out !== 1'b0 ||
          bus.done_out !== 1'b0 || bus0.y_out !== 1'b0 || bus0.ready_out !== 1'b1) begin
        n_fails++;
        $display("FAIL idle_hold[%0d]: y=%b ready=%b busy=%b done=%b y0=%b ready0=%b, want 0 1 0 0 0 1",
                 c, bus.y_out, bus.ready_out, bus.busy_out, bus.done_out, bus0.y_out,
                 bus0.ready_out);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [10:0] bits, dones;
    int cyc;
    bus.data_in = 8'hA5;
    bus.load_in = 1'b1;
    capture_frame(1'b0, -1, 8'h00, bits, dones);
    n_checks++;
    if (bits !== 11'b1_10100101_0_0) begin
      n_fails++;
      $display("FAIL frame_a5: got %b, want %b", bits, 11'b1_10100101_0_0);
    end
    n_checks++;
    if (dones !== 11'b00000000001) begin
      n_fails++;
      $display("FAIL done_a5: got %b, want %b", dones, 11'b00000000001);
    end
    wait_ready(cyc);
    n_checks++;
    if (10 + cyc !== 13) begin
      n_fails++;
      $display("FAIL ready_latency_a5: got %0d cycles, want 13", 10 + cyc);
    end
  endtask

  task automatic test_parity();
    logic [10:0] bits, dones;
    int cyc;
    bus.data_in = 8'h07;
    bus.load_in = 1'b1;
    capture_frame(1'b0, -1, 8'h00, bits, dones);
    n_checks++;
    if (bits !== 11'b1_00000111_1_0) begin
      n_fails++;
      $display("FAIL frame_07: got %b, want %b", bits, 11'b1_00000111_1_0);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_fails++;
      $display("FAIL ready_latency_07: got %0d cycles, want 13", 10 + cyc);
    end
    bus.data_in = 8'h00;
    bus.load_in = 1'b1;
    capture_frame(1'b0, -1, 8'h00, bits, dones);
    n_checks++;
    if (bits !== 11'b1_00000000_0_0) begin
      n_fails++;
      $display("FAIL frame_00: got %b, want %b", bits, 11'b1_00000000_0_0);
    end
    n_checks++;
    if (dones !== 11'b00000000001) begin
      n_fails++;
      $display("FAIL done_00: got %b, want %b", dones, 11'b00000000001);
    end
    wait_ready(cyc);
  endtask

  task automatic test_load_while_busy();
    logic [10:0] bits, dones;
    int cyc;
    bus.data_in = 8'hFF;
    bus.load_in = 1'b1;
    capture_frame(1'b0, 3, 8'h00, bits, dones);
    n_checks++;
    if (bits !== 11'b1_11111111_0_0) begin
      n_fails++;
      $display("FAIL frame_ff_busy_load: got %b, want %b", bits, 11'b1_11111111_0_0);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_fails++;
      $display("FAIL ready_latency_ff: got %0d cycles, want 13", 10 + cyc);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (bus.y_out !== 1'b0 || bus.busy_out !== 1'b0) begin
        n_fails++;
        $display("FAIL no_second_frame[%0d]: y=%b busy=%b, want 0 0", c, bus.y_out, bus.busy_out);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits, dones;
    int cyc;
    bus.data_in = 8'hA5;
    bus.load_in = 1'b1;
    @(posedge clock); #1;
    bus.load_in = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    n_checks++;
    if (bus.y_out !== 1'b1 || bus.busy_out !== 1'b1) begin
      n_fails++;
      $display("FAIL third_data_bit: y=%b busy=%b, want 1 1", bus.y_out, bus.busy_out);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.y_out !== 1'b0 || bus.ready_out !== 1'b1 || bus.busy_out !== 1'b0 ||
        bus.done_out !== 1'b0) begin
      n_fails++;
      $display("FAIL async_reset: y=%b ready=%b busy=%b done=%b, want 0 1 0 0",
               bus.y_out, bus.ready_out, bus.busy_out, bus.done_out);
    end
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (bus.ready_out !== 1'b1 || bus.y_out !== 1'b0) begin
      n_fails++;
      $display("FAIL after_reset_idle: ready=%b y=%b, want 1 0", bus.ready_out, bus.y_out);
    end
    bus.data_in = 8'h3C;
    bus.load_in = 1'b1;
    capture_frame(1'b0, -1, 8'h00, bits, dones);
    n_checks++;
    if (bits !== 11'b1_00111100_0_0) begin
      n_fails++;
      $display("FAIL frame_3c: got %b, want %b", bits, 11'b1_00111100_0_0);
    end
    n_checks++;
    if (dones !== 11'b00000000001) begin
      n_fails++;
      $display("FAIL done_3c: got %b, want %b", dones, 11'b00000000001);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_fails++;
      $display("FAIL ready_latency_3c: got %0d cycles, want 13", 10 + cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] stream;
    logic [22:0] want;
    int first_done;
    int second_done;
    want = {11'b1_10000001_0_0, 1'b0, 11'b1_00011000_0_0};
    first_done  = -1;
    second_done = -1;
    bus0.data_in = 8'h81;
    bus0.load_in = 1'b1;
    @(posedge clock); #1;
    bus0.data_in = 8'h18;
    for (int i = 0; i < 23; i++) begin
      stream[22-i] = bus0.y_out;
      if (bus0.done_out === 1'b1) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
      if (i == 11) begin
        n_checks++;
        if (bus0.ready_out !== 1'b1) begin
          n_fails++;
          $display("FAIL b2b_idle_gap: ready=%b, want 1", bus0.ready_out);
        end
      end
      if (i == 12) bus0.load_in = 1'b0;
      if (i < 22) begin
        @(posedge clock); #1;
      end
    end
    n_checks++;
    if (stream !== want) begin
      n_fails++;
      $display("FAIL b2b_stream: got %b, want %b", stream, want);
    end
    n_checks++;
    if (first_done !== 10 || second_done - first_done !== 12) begin
      n_fails++;
      $display("FAIL b2b_done_spacing: first=%0d second=%0d, want 10 22",
               first_done, second_done);
    end
    repeat (2) begin
      @(posedge clock); #1;
    end
    n_checks++;
    if (bus0.ready_out !== 1'b1 || bus0.y_out !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_settle: ready=%b y=%b, want 1 0", bus0.ready_out, bus0.y_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_single_frame();
    test_parity();
    test_load_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
